// File: rtl/garage_door_supervisor.sv
// Garage door supervisor: arbitrates wall / keypad / remote requests, runs the
// door motor FSM, auto-closes an open door, and latches a fault on motor
// watchdog expiry or contradictory limit sensors.
//
// Optional feature macro: OBSTACLE_REVERSE_EN
//   defined   - obstacle in CLOSING reverses to OPENING; commands in PAUSE_CLOSE
//               are ignored while obstacle is high
//   undefined - obstacle input is ignored (port kept)
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   wall       wall button (level)
//   keypad     keypad-accepted (level)
//   remote     remote button (level)
//   open       door-fully-open sensor
//   closed     door-fully-closed sensor
//   obstacle   beam-broken sensor
//   power      1 = motor on
//   direction  0 = open, 1 = close
//   fault      1 = latched fault
//   grant      0 none, 1 wall, 2 keypad, 3 remote; one-cycle pulse per command
//   state      current FSM state
//
// Parameters (all must be >= 1):
//   AUTOCLOSE_CYC  cycles spent in OPEN before auto-close
//   RUN_MAX_CYC    consecutive motor-on cycles before FAULT
//   LOCKOUT_CYC    cycles after an accepted command during which edges are dropped
module garage_door_supervisor #(
  parameter int unsigned AUTOCLOSE_CYC = 30,
  parameter int unsigned RUN_MAX_CYC   = 100,
  parameter int unsigned LOCKOUT_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wall,
  input  logic       keypad,
  input  logic       remote,
  input  logic       open,
  input  logic       closed,
  input  logic       obstacle,
  output logic       power,
  output logic       direction,
  output logic       fault,
  output logic [1:0] grant,
  output logic [2:0] state
);

  // Auto-close and run counters only ever hold values up to (limit - 1),
  // because reaching the limit forces a state change that clears them.
  localparam int unsigned AcW   = (AUTOCLOSE_CYC > 1) ? $clog2(AUTOCLOSE_CYC) : 1;
  localparam int unsigned RunW  = (RUN_MAX_CYC > 1) ? $clog2(RUN_MAX_CYC) : 1;
  localparam int unsigned LockW = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    StClosed     = 3'b000,
    StOpening    = 3'b001,
    StOpen       = 3'b010,
    StPauseOpen  = 3'b011,
    StClosing    = 3'b100,
    StPauseClose = 3'b101,
    StFault      = 3'b110
  } state_e;

  state_e           state_q, state_d;
  logic             wall_prev_q, keypad_prev_q, remote_prev_q;
  logic [LockW-1:0] lock_q, lock_d;
  logic [AcW-1:0]   ac_q, ac_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [1:0]       grant_q, grant_d;

  logic [2:0] req_edge;
  logic       cmd;
  logic [1:0] winner;
  logic       contradiction;
  logic       watchdog_hit;
  logic       ac_done;
  logic       obst_active;

`ifdef OBSTACLE_REVERSE_EN
  assign obst_active = obstacle;
`else
  logic unused_obstacle;
  assign unused_obstacle = obstacle;
  assign obst_active     = 1'b0;
`endif

  // Rising-edge detect; prev registers reset high so levels held through reset
  // never look like a fresh press.
  assign req_edge = {wall & ~wall_prev_q, keypad & ~keypad_prev_q, remote & ~remote_prev_q};

  assign cmd = (|req_edge) && (lock_q == '0) && (state_q != StFault);

  // Fixed priority wall > keypad > remote; losers are simply dropped.
  always_comb begin
    winner = 2'd0;
    if (req_edge[2]) begin
      winner = 2'd1;
    end else if (req_edge[1]) begin
      winner = 2'd2;
    end else if (req_edge[0]) begin
      winner = 2'd3;
    end
  end

  assign contradiction = open & closed;
  assign watchdog_hit  = (run_q == RunW'(RUN_MAX_CYC - 1));
  assign ac_done       = (ac_q == AcW'(AUTOCLOSE_CYC - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StClosed: begin
        if (cmd) state_d = StOpening;
      end
      StOpening: begin
        if (watchdog_hit || contradiction) begin
          state_d = StFault;
        end else if (cmd) begin
          state_d = StPauseOpen;
        end else if (open) begin
          state_d = StOpen;
        end
      end
      StOpen: begin
        if (cmd || ac_done) state_d = StClosing;
      end
      StPauseOpen: begin
        if (cmd) state_d = StOpening;
      end
      StClosing: begin
        if (watchdog_hit || contradiction) begin
          state_d = StFault;
        end else if (obst_active) begin
          state_d = StOpening;
        end else if (cmd) begin
          state_d = StPauseClose;
        end else if (closed) begin
          state_d = StClosed;
        end
      end
      StPauseClose: begin
        if (cmd && !obst_active) state_d = StClosing;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StClosed;
      end
    endcase
  end

  // Counters and grant next-state
  always_comb begin
    grant_d = cmd ? winner : 2'd0;

    lock_d = lock_q;
    if (cmd) begin
      lock_d = LockW'(LOCKOUT_CYC);
    end else if (lock_q != '0) begin
      lock_d = lock_q - 1'b1;
    end

    // Run counter restarts on every entry into a motor state, including resume.
    run_d = '0;
    if ((state_d == StOpening || state_d == StClosing) && (state_d == state_q)) begin
      run_d = run_q + 1'b1;
    end

    ac_d = '0;
    if ((state_q == StOpen) && (state_d == StOpen)) begin
      ac_d = ac_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StClosed;
      wall_prev_q   <= 1'b1;
      keypad_prev_q <= 1'b1;
      remote_prev_q <= 1'b1;
      lock_q        <= '0;
      ac_q          <= '0;
      run_q         <= '0;
      grant_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      wall_prev_q   <= wall;
      keypad_prev_q <= keypad;
      remote_prev_q <= remote;
      lock_q        <= lock_d;
      ac_q          <= ac_d;
      run_q         <= run_d;
      grant_q       <= grant_d;
    end
  end

  // Moore outputs
  always_comb begin
    power     = (state_q == StOpening) || (state_q == StClosing);
    direction = (state_q == StClosing);
    fault     = (state_q == StFault);
    grant     = grant_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_garage_door_supervisor.sv
// Directed bench for garage_door_supervisor at default parameters. Each step
// drives inputs, queues the expected post-edge outputs, then checks them.
module tb_garage_door_supervisor;

  localparam logic [2:0] S_CLOSED      = 3'd0;
  localparam logic [2:0] S_OPENING     = 3'd1;
  localparam logic [2:0] S_OPEN        = 3'd2;
  localparam logic [2:0] S_PAUSE_OPEN  = 3'd3;
  localparam logic [2:0] S_CLOSING     = 3'd4;
  localparam logic [2:0] S_PAUSE_CLOSE = 3'd5;
  localparam logic [2:0] S_FAULT       = 3'd6;

  logic       clk;
  logic       reset;
  logic       wall, keypad, remote;
  logic       door_open, door_closed, obstacle;
  logic       power, direction, fault;
  logic [1:0] grant;
  logic [2:0] state;

  typedef struct {
    string      tag;
    logic [7:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  garage_door_supervisor dut (
    .clk       (clk),
    .reset     (reset),
    .wall      (wall),
    .keypad    (keypad),
    .remote    (remote),
    .open      (door_open),
    .closed    (door_closed),
    .obstacle  (obstacle),
    .power     (power),
    .direction (direction),
    .fault     (fault),
    .grant     (grant),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the Moore output table: {state, power, direction, fault, grant}
  function automatic logic [7:0] pack_exp(input logic [2:0] st, input logic [1:0] gr);
    logic pw, dr, ft;
    pw = (st == S_OPENING) || (st == S_CLOSING);
    dr = (st == S_CLOSING);
    ft = (st == S_FAULT);
    return {st, pw, dr, ft, gr};
  endfunction

  // Current inputs are sampled at the next rising edge; outputs checked at the
  // following falling edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [1:0] gr);
    exp_t       e;
    logic [7:0] obs;
    e.tag = tag;
    e.vec = pack_exp(st, gr);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e   = sb.pop_front();
    obs = {state, power, direction, fault, grant};
    n_assert++;
    assert (obs === e.vec) else begin
      n_fail++;
      $error("FAIL %s: observed state=%0d pwr=%b dir=%b flt=%b grant=%0d, expected state=%0d pwr=%b dir=%b flt=%b grant=%0d",
             e.tag, obs[7:5], obs[4], obs[3], obs[2], obs[1:0],
             e.vec[7:5], e.vec[4], e.vec[3], e.vec[2], e.vec[1:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    wall        = 1'b0;
    keypad      = 1'b0;
    remote      = 1'b1;
    door_open   = 1'b0;
    door_closed = 1'b1;
    obstacle    = 1'b0;

    // Reset with remote held high
    cyc("reset", S_CLOSED, 2'd0);
    cyc("reset", S_CLOSED, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc("held_through_reset", S_CLOSED, 2'd0);

    // Normal cycle: open, auto-close
    remote = 1'b0;
    cyc("idle", S_CLOSED, 2'd0);
    remote = 1'b1;
    cyc("remote_go", S_OPENING, 2'd3);
    remote      = 1'b0;
    door_closed = 1'b0;
    for (int i = 0; i < 9; i++) cyc("opening", S_OPENING, 2'd0);
    door_open = 1'b1;
    cyc("open_reached", S_OPEN, 2'd0);
    for (int i = 1; i < 30; i++) cyc("open_wait", S_OPEN, 2'd0);
    cyc("autoclose", S_CLOSING, 2'd0);
    door_open = 1'b0;
    cyc("closing", S_CLOSING, 2'd0);
    cyc("closing", S_CLOSING, 2'd0);

    // Reset mid-travel
    reset = 1'b1;
    cyc("reset_mid_closing", S_CLOSED, 2'd0);
    reset       = 1'b0;
    door_closed = 1'b1;
    cyc("idle2", S_CLOSED, 2'd0);

    // Arbitration and lockout
    wall   = 1'b1;
    remote = 1'b1;
    cyc("arb_wall_wins", S_OPENING, 2'd1);
    wall        = 1'b0;
    remote      = 1'b0;
    door_closed = 1'b0;
    cyc("grant_one_cycle", S_OPENING, 2'd0);
    remote = 1'b1;
    cyc("lockout_ignored", S_OPENING, 2'd0);
    remote = 1'b0;
    cyc("lockout", S_OPENING, 2'd0);
    cyc("lockout", S_OPENING, 2'd0);
    remote = 1'b1;
    cyc("after_lockout", S_PAUSE_OPEN, 2'd3);
    remote = 1'b0;
    for (int i = 0; i < 4; i++) cyc("pause_open_hold", S_PAUSE_OPEN, 2'd0);
    keypad = 1'b1;
    remote = 1'b1;
    cyc("arb_keypad_wins", S_OPENING, 2'd2);
    keypad = 1'b0;
    remote = 1'b0;
    for (int i = 0; i < 4; i++) cyc("resumed_opening", S_OPENING, 2'd0);
    door_open = 1'b1;
    cyc("reopen", S_OPEN, 2'd0);
    wall = 1'b1;
    cyc("open_cmd_close", S_CLOSING, 2'd1);
    wall      = 1'b0;
    door_open = 1'b0;
    for (int i = 0; i < 4; i++) cyc("closing2", S_CLOSING, 2'd0);

    // Obstacle
    obstacle = 1'b1;
`ifdef OBSTACLE_REVERSE_EN
    cyc("obstacle_reverse", S_OPENING, 2'd0);
`else
    cyc("obstacle_ignored", S_CLOSING, 2'd0);
`endif
    obstacle = 1'b0;
    remote   = 1'b1;
`ifdef OBSTACLE_REVERSE_EN
    cyc("pause_after_obst", S_PAUSE_OPEN, 2'd3);
`else
    cyc("pause_after_obst", S_PAUSE_CLOSE, 2'd3);
`endif
    remote = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef OBSTACLE_REVERSE_EN
      cyc("pause_hold", S_PAUSE_OPEN, 2'd0);
`else
      cyc("pause_hold", S_PAUSE_CLOSE, 2'd0);
`endif
    end
    remote = 1'b1;
`ifdef OBSTACLE_REVERSE_EN
    cyc("resume", S_OPENING, 2'd3);
    remote    = 1'b0;
    door_open = 1'b1;
    cyc("resume_end", S_OPEN, 2'd0);
    door_open = 1'b0;
`else
    cyc("resume", S_CLOSING, 2'd3);
    remote      = 1'b0;
    door_closed = 1'b1;
    cyc("resume_end", S_CLOSED, 2'd0);
    door_closed = 1'b0;
`endif

    // Sensor contradiction, then fault latching
    reset = 1'b1;
    cyc("reset2", S_CLOSED, 2'd0);
    reset       = 1'b0;
    door_closed = 1'b1;
    cyc("idle3", S_CLOSED, 2'd0);
    remote = 1'b1;
    cyc("go2", S_OPENING, 2'd3);
    remote      = 1'b0;
    door_closed = 1'b0;
    cyc("opening3", S_OPENING, 2'd0);
    door_open   = 1'b1;
    door_closed = 1'b1;
    cyc("contradiction", S_FAULT, 2'd0);
    door_open   = 1'b0;
    door_closed = 1'b0;
    for (int i = 0; i < 3; i++) cyc("fault_hold", S_FAULT, 2'd0);
    remote = 1'b1;
    cyc("fault_no_grant", S_FAULT, 2'd0);
    remote = 1'b0;
    cyc("fault_hold2", S_FAULT, 2'd0);

    // Watchdog
    reset = 1'b1;
    cyc("reset_from_fault", S_CLOSED, 2'd0);
    reset       = 1'b0;
    door_closed = 1'b1;
    cyc("idle4", S_CLOSED, 2'd0);
    remote = 1'b1;
    cyc("go3", S_OPENING, 2'd3);
    remote      = 1'b0;
    door_closed = 1'b0;
    for (int i = 1; i < 100; i++) cyc("watchdog_run", S_OPENING, 2'd0);
    cyc("watchdog_fault", S_FAULT, 2'd0);
    for (int i = 0; i < 4; i++) cyc("wd_fault_hold", S_FAULT, 2'd0);
    remote = 1'b1;
    cyc("wd_fault_no_grant", S_FAULT, 2'd0);
    remote = 1'b0;
    reset  = 1'b1;
    cyc("reset_final", S_CLOSED, 2'd0);
    reset = 1'b0;
    cyc("idle_final", S_CLOSED, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
